mips_multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath; sits directly upstream of `alu_control_unit` and drives its 3-bit `alu_op`. It sequences fetch/decode/execute/memory/writeback per opcode, produces all datapath enables and muxes, and stalls on a memory ready handshake. It also counts retired instructions and flags illegal opcodes.

---
 rtl/mips_multicycle_control_pkg.sv | 75 +++++++
 rtl/mips_multicycle_control_if.sv | 38 +++
 rtl/mips_multicycle_control_output_decode.sv | 82 ++++++++
 rtl/mips_multicycle_control.sv | 86 ++++++++
 tb/tb_mips_multicycle_control.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: state codes,
// opcodes, ALUOp/mux encodings and the decoded control bundle.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  // ALUOp encodings shared with alu_control_unit
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_RTY = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      OP_SLTI: imm_alu_op = ALU_SLT;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the main control FSM and the multi-cycle datapath.
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             pc_write_cond_ne;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_source, illegal_op, state, instr_retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_source, illegal_op, state, instr_retired
  );
endinterface

// File: rtl/mips_multicycle_control_output_decode.sv
// Moore-style output decode of the control FSM; only FETCH PC/IR loads
// look at mem_ready, and DECODE/IMMEX/BRANCH refine by opcode.
module control_output_decode
  import mips_multicycle_control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: ctrl.illegal_op = 1'b0;
          default:                                ctrl.illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_RTY;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a        = 1'b1;
        ctrl.alu_src_b        = SRCB_B;
        ctrl.alu_op           = ALU_SUB;
        ctrl.pc_source        = PCSRC_ALUOUT;
        ctrl.pc_write_cond    = (opcode == OP_BEQ);
        ctrl.pc_write_cond_ne = (opcode == OP_BNE);
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(opcode);
      end
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register,
// next-state sequencing, retired-instruction counter and reset gating.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  mips_multicycle_control_if.master bus
);

  state_t           state, state_next;
  logic [CNT_W-1:0] retired;
  logic             retire;
  ctrl_t            ctrl;

  control_output_decode u_decode (
    .state     (state),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= state_next;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state)
      S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:                      state_next = S_MEMADR;
          OP_R:                              state_next = S_EXEC;
          OP_BEQ, OP_BNE:                    state_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IMMEX;
          OP_J:                              state_next = S_JUMP;
          default:                           state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
        retire     = bus.mem_ready;
      end
      S_EXEC:   state_next = S_ALUWB;
      S_IMMEX:  state_next = S_IMMWB;
      // Last cycle of a completed instruction: count it on the way to FETCH
      S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default:  state_next = S_FETCH;
    endcase
  end

  // State-changing strobes are held off for as long as reset is asserted
  assign bus.pc_write         = ctrl.pc_write & reset_n;
  assign bus.pc_write_cond    = ctrl.pc_write_cond & reset_n;
  assign bus.pc_write_cond_ne = ctrl.pc_write_cond_ne & reset_n;
  assign bus.mem_read         = ctrl.mem_read & reset_n;
  assign bus.mem_write        = ctrl.mem_write & reset_n;
  assign bus.ir_write         = ctrl.ir_write & reset_n;
  assign bus.reg_write        = ctrl.reg_write & reset_n;
  assign bus.iord             = ctrl.iord;
  assign bus.reg_dst          = ctrl.reg_dst;
  assign bus.mem_to_reg       = ctrl.mem_to_reg;
  assign bus.alu_src_a        = ctrl.alu_src_a;
  assign bus.alu_src_b        = ctrl.alu_src_b;
  assign bus.alu_op           = ctrl.alu_op;
  assign bus.pc_source        = ctrl.pc_source;
  assign bus.illegal_op       = ctrl.illegal_op;
  assign bus.state            = state;
  assign bus.instr_retired    = retired;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed per-cycle vectors for the multi-cycle MIPS control FSM; a
// scoreboard queue holds expected outputs, a monitor checks them mid-cycle.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.CNT_W(32)) bus ();

  mips_multicycle_control #(.CNT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // {pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write,
  //  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
  //  alu_op, pc_source, illegal_op}
  localparam logic [18:0] C_FETCH_RDY  = 19'b100_010_1000_0_01_000_00_0;
  localparam logic [18:0] C_FETCH_WAIT = 19'b000_010_0000_0_01_000_00_0;
  localparam logic [18:0] C_FETCH_RST  = 19'b000_000_0000_0_01_000_00_0;
  localparam logic [18:0] C_DECODE     = 19'b000_000_0000_0_11_000_00_0;
  localparam logic [18:0] C_DECODE_ILL = 19'b000_000_0000_0_11_000_00_1;
  localparam logic [18:0] C_MEMADR     = 19'b000_000_0000_1_10_000_00_0;
  localparam logic [18:0] C_MEMRD      = 19'b000_110_0000_0_00_000_00_0;
  localparam logic [18:0] C_MEMWB      = 19'b000_000_0011_0_00_000_00_0;
  localparam logic [18:0] C_MEMWR      = 19'b000_101_0000_0_00_000_00_0;
  localparam logic [18:0] C_EXEC       = 19'b000_000_0000_1_00_010_00_0;
  localparam logic [18:0] C_ALUWB      = 19'b000_000_0101_0_00_000_00_0;
  localparam logic [18:0] C_BR_EQ      = 19'b010_000_0000_1_00_001_01_0;
  localparam logic [18:0] C_BR_NE      = 19'b001_000_0000_1_00_001_01_0;
  localparam logic [18:0] C_IMMEX_AND  = 19'b000_000_0000_1_10_100_00_0;
  localparam logic [18:0] C_IMMWB      = 19'b000_000_0001_0_00_000_00_0;
  localparam logic [18:0] C_JUMP       = 19'b100_000_0000_0_00_000_10_0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ANDI = 6'b001100;
  localparam logic [5:0] J = 6'b000010, ILL = 6'b111111;

  typedef struct {
    int          id;
    logic [3:0]  st;
    logic [18:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   step_id = 0;
  logic done = 1'b0;

  task automatic step(input logic rst_v, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic [18:0] ctl,
                      input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n       = rst_v;
    bus.opcode    = op;
    bus.mem_ready = mr;
    e.id  = step_id;
    e.st  = st;
    e.ctl = ctl;
    e.cnt = cnt;
    q.push_back(e);
    step_id++;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {bus.pc_write, bus.pc_write_cond, bus.pc_write_cond_ne, bus.iord,
               bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
               bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
               bus.alu_op, bus.pc_source, bus.illegal_op};
        total++;
        if (bus.state !== e.st) begin
          bad++;
          $display("FAIL step%0d state: got %0d want %0d", e.id, bus.state, e.st);
        end
        total++;
        if (act !== e.ctl) begin
          bad++;
          $display("FAIL step%0d ctrl: got %b want %b", e.id, act, e.ctl);
        end
        total++;
        if (bus.instr_retired !== e.cnt) begin
          bad++;
          $display("FAIL step%0d retired: got %0d want %0d", e.id, bus.instr_retired, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    bus.opcode    = LW;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    step(1'b0, LW, 1'b1, 4'd0, C_FETCH_RST, 0);
    // j: 3 cycles
    step(1'b1, J, 1'b1, 4'd0,  C_FETCH_RDY, 0);
    step(1'b1, J, 1'b1, 4'd1,  C_DECODE,    0);
    step(1'b1, J, 1'b1, 4'd11, C_JUMP,      0);
    // lw aborted by reset while waiting in MEMRD
    step(1'b1, LW, 1'b1, 4'd0, C_FETCH_RDY, 1);
    step(1'b1, LW, 1'b1, 4'd1, C_DECODE,    1);
    step(1'b1, LW, 1'b1, 4'd2, C_MEMADR,    1);
    step(1'b1, LW, 1'b0, 4'd3, C_MEMRD,     1);
    step(1'b0, LW, 1'b0, 4'd0, C_FETCH_RST, 0);
    step(1'b1, LW, 1'b0, 4'd0, C_FETCH_WAIT, 0);
    // lw full, mem_ready high: 5 cycles
    step(1'b1, LW, 1'b1, 4'd0, C_FETCH_RDY, 0);
    step(1'b1, LW, 1'b1, 4'd1, C_DECODE,    0);
    step(1'b1, LW, 1'b1, 4'd2, C_MEMADR,    0);
    step(1'b1, LW, 1'b1, 4'd3, C_MEMRD,     0);
    step(1'b1, LW, 1'b1, 4'd4, C_MEMWB,     0);
    // sw with three wait cycles in MEMWR: 7 cycles
    step(1'b1, SW, 1'b1, 4'd0, C_FETCH_RDY, 1);
    step(1'b1, SW, 1'b1, 4'd1, C_DECODE,    1);
    step(1'b1, SW, 1'b1, 4'd2, C_MEMADR,    1);
    step(1'b1, SW, 1'b0, 4'd5, C_MEMWR,     1);
    step(1'b1, SW, 1'b0, 4'd5, C_MEMWR,     1);
    step(1'b1, SW, 1'b0, 4'd5, C_MEMWR,     1);
    step(1'b1, SW, 1'b1, 4'd5, C_MEMWR,     1);
    // R-type with one fetch wait; mem_ready low in DECODE/EXEC is ignored
    step(1'b1, R, 1'b0, 4'd0, C_FETCH_WAIT, 2);
    step(1'b1, R, 1'b1, 4'd0, C_FETCH_RDY,  2);
    step(1'b1, R, 1'b0, 4'd1, C_DECODE,     2);
    step(1'b1, R, 1'b0, 4'd6, C_EXEC,       2);
    step(1'b1, R, 1'b1, 4'd7, C_ALUWB,      2);
    // andi
    step(1'b1, ANDI, 1'b1, 4'd0,  C_FETCH_RDY, 3);
    step(1'b1, ANDI, 1'b1, 4'd1,  C_DECODE,    3);
    step(1'b1, ANDI, 1'b1, 4'd9,  C_IMMEX_AND, 3);
    step(1'b1, ANDI, 1'b1, 4'd10, C_IMMWB,     3);
    // beq then bne
    step(1'b1, BEQ, 1'b1, 4'd0, C_FETCH_RDY, 4);
    step(1'b1, BEQ, 1'b1, 4'd1, C_DECODE,    4);
    step(1'b1, BEQ, 1'b1, 4'd8, C_BR_EQ,     4);
    step(1'b1, BNE, 1'b1, 4'd0, C_FETCH_RDY, 5);
    step(1'b1, BNE, 1'b1, 4'd1, C_DECODE,    5);
    step(1'b1, BNE, 1'b1, 4'd8, C_BR_NE,     5);
    // illegal opcode: 2 cycles, counter unchanged
    step(1'b1, ILL, 1'b1, 4'd0, C_FETCH_RDY,  6);
    step(1'b1, ILL, 1'b1, 4'd1, C_DECODE_ILL, 6);
    step(1'b1, R,   1'b0, 4'd0, C_FETCH_WAIT, 6);
    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done);
      #20000;
    join_any
    disable fork;
    total++;
    if (!done || q.size() != 0) begin
      bad++;
      $display("FAIL drain: done=%0d pending=%0d want done=1 pending=0", done, q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
